// File: rtl/usr_pkg.sv
// Shared types for the universal shift register: operation modes and the
// shift direction remembered by the word counter.
package usr_pkg;

  // Operation select applied at each rising Clock edge.
  typedef enum logic [1:0] {
    USR_HOLD = 2'b00,
    USR_SHR  = 2'b01,
    USR_SHL  = 2'b10,
    USR_LOAD = 2'b11
  } usr_mode_e;

  // Direction of the shift run currently being counted.
  typedef enum logic {
    DIR_RIGHT = 1'b0,
    DIR_LEFT  = 1'b1
  } usr_dir_e;

  // True for the two modes that move data and advance the counter.
  function automatic logic is_shift(usr_mode_e m);
    return (m == USR_SHR) || (m == USR_SHL);
  endfunction

  // Direction implied by a shift mode. Only meaningful when is_shift(m).
  function automatic usr_dir_e shift_dir(usr_mode_e m);
    return (m == USR_SHL) ? DIR_LEFT : DIR_RIGHT;
  endfunction

endpackage

// File: rtl/usr_bit_cell.sv
// One bit of the universal shift register: a 4:1 next-state mux feeding a
// synchronously reset flop. left_nb is the neighbour on the MSB side (source
// during a right shift), right_nb the neighbour on the LSB side (source
// during a left shift).
import usr_pkg::*;

module usr_bit_cell #(
  parameter logic RESET_BIT = 1'b0
) (
  input  logic      Clock,
  input  logic      reset,
  input  usr_mode_e mode,
  input  logic      left_nb,
  input  logic      right_nb,
  input  logic      par_bit,
  output logic      q
);

  logic d;

  // Select the next value of this bit from the operation mode.
  always_comb begin
    d = q;
    case (mode)
      USR_HOLD: d = q;
      USR_SHR:  d = left_nb;
      USR_SHL:  d = right_nb;
      USR_LOAD: d = par_bit;
      default:  d = q;
    endcase
  end

  // Storage flop; reset has priority over any mode.
  always_ff @(posedge Clock) begin
    if (reset) begin
      q <= RESET_BIT;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/universal_shift_register.sv
// WIDTH-bit universal shift register (hold / shift right / shift left /
// parallel load) with a same-direction shift counter that pulses word_ready
// once every WIDTH consecutive shifts in one direction. Holds do not break a
// run; a load or a direction change restarts it.
import usr_pkg::*;

module universal_shift_register #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                       Clock,
  input  logic                       reset,
  input  logic [1:0]                 mode,
  input  logic [WIDTH-1:0]           par_in,
  input  logic                       sin_right,
  input  logic                       sin_left,
  output logic [WIDTH-1:0]           Res,
  output logic                       sout_lsb,
  output logic                       sout_msb,
  output logic [$clog2(WIDTH+1)-1:0] shift_count,
  output logic                       word_ready
);

  localparam int             CW        = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  WIDTH_CNT = CW'(WIDTH);
  localparam logic [CW-1:0]  ONE_CNT   = CW'(1);

  usr_mode_e        mode_e;
  logic [WIDTH-1:0] res_q;

  usr_dir_e         dir_q;
  usr_dir_e         dir_next;
  logic [CW-1:0]    count_next;
  logic [CW-1:0]    count_inc;
  logic             ready_next;

  assign mode_e = usr_mode_e'(mode);

  // Datapath: one cell per bit, with the serial inputs feeding the end cells.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic left_src;
    logic right_src;

    if (i == WIDTH - 1) begin : g_msb
      assign left_src = sin_right;
    end else begin : g_mid_l
      assign left_src = res_q[i+1];
    end

    if (i == 0) begin : g_lsb
      assign right_src = sin_left;
    end else begin : g_mid_r
      assign right_src = res_q[i-1];
    end

    usr_bit_cell #(
      .RESET_BIT (RESET_VALUE[i])
    ) u_cell (
      .Clock    (Clock),
      .reset    (reset),
      .mode     (mode_e),
      .left_nb  (left_src),
      .right_nb (right_src),
      .par_bit  (par_in[i]),
      .q        (res_q[i])
    );
  end

  assign Res      = res_q;
  assign sout_lsb = res_q[0];
  assign sout_msb = res_q[WIDTH-1];

  // Next counter/direction state: count same-direction shifts, restart at 1
  // on a direction change, wrap to 0 with a pulse at a full word.
  always_comb begin
    count_next = shift_count;
    dir_next   = dir_q;
    ready_next = 1'b0;
    count_inc  = '0;
    if (is_shift(mode_e)) begin
      if (shift_dir(mode_e) == dir_q) begin
        count_inc = shift_count + ONE_CNT;
      end else begin
        count_inc = ONE_CNT;
        dir_next  = shift_dir(mode_e);
      end
      if (count_inc == WIDTH_CNT) begin
        count_next = '0;
        ready_next = 1'b1;
      end else begin
        count_next = count_inc;
      end
    end else if (mode_e == USR_LOAD) begin
      count_next = '0;
    end
  end

  // Counter, direction and word_ready registers.
  always_ff @(posedge Clock) begin
    if (reset) begin
      shift_count <= '0;
      dir_q       <= DIR_RIGHT;
      word_ready  <= 1'b0;
    end else begin
      shift_count <= count_next;
      dir_q       <= dir_next;
      word_ready  <= ready_next;
    end
  end

endmodule

// File: tb/tb_universal_shift_register.sv
// Self-checking bench for universal_shift_register: a directed vector table
// for the main scenarios plus hand-written multi-cycle sequences, and a
// narrow instance with a non-zero reset value.
import usr_pkg::*;

module tb_universal_shift_register;

  logic       Clock = 1'b0;
  always #5 Clock = ~Clock;

  // WIDTH=8 instance
  logic       reset;
  logic [1:0] mode;
  logic [7:0] par_in;
  logic       sin_right, sin_left;
  logic [7:0] Res;
  logic       sout_lsb, sout_msb;
  logic [3:0] shift_count;
  logic       word_ready;

  // WIDTH=4 instance, RESET_VALUE=4'hA
  logic       reset4;
  logic [1:0] mode4;
  logic [3:0] par_in4;
  logic       sin_right4, sin_left4;
  logic [3:0] res4;
  logic       sout_lsb4, sout_msb4;
  logic [2:0] shift_count4;
  logic       word_ready4;

  universal_shift_register #(.WIDTH(8), .RESET_VALUE(8'h00)) dut (
    .Clock       (Clock),
    .reset       (reset),
    .mode        (mode),
    .par_in      (par_in),
    .sin_right   (sin_right),
    .sin_left    (sin_left),
    .Res         (Res),
    .sout_lsb    (sout_lsb),
    .sout_msb    (sout_msb),
    .shift_count (shift_count),
    .word_ready  (word_ready)
  );

  universal_shift_register #(.WIDTH(4), .RESET_VALUE(4'hA)) dut4 (
    .Clock       (Clock),
    .reset       (reset4),
    .mode        (mode4),
    .par_in      (par_in4),
    .sin_right   (sin_right4),
    .sin_left    (sin_left4),
    .Res         (res4),
    .sout_lsb    (sout_lsb4),
    .sout_msb    (sout_msb4),
    .shift_count (shift_count4),
    .word_ready  (word_ready4)
  );

  typedef struct {
    logic       rst;
    logic [1:0] md;
    logic [7:0] par;
    logic       sr;
    logic       sl;
    logic [7:0] res;
    logic [3:0] cnt;
    logic       wr;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  task automatic add(input logic rst, input logic [1:0] md, input logic [7:0] par,
                     input logic sr, input logic sl,
                     input logic [7:0] res, input logic [3:0] cnt, input logic wr);
    vec_t v;
    v.rst = rst; v.md = md; v.par = par; v.sr = sr; v.sl = sl;
    v.res = res; v.cnt = cnt; v.wr = wr;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h need 0x%0h", name, act, exp);
    end
  endtask

  // Drive one edge on the 8-bit instance; outputs are sampled 1 ns later.
  task automatic step(input logic rst, input logic [1:0] md, input logic [7:0] par,
                      input logic sr, input logic sl);
    @(negedge Clock);
    reset = rst; mode = md; par_in = par; sin_right = sr; sin_left = sl;
    @(posedge Clock);
    #1;
  endtask

  task automatic step4(input logic rst, input logic [1:0] md, input logic sr);
    @(negedge Clock);
    reset4 = rst; mode4 = md; sin_right4 = sr;
    @(posedge Clock);
    #1;
  endtask

  initial begin
    logic [7:0]  sr_bits;
    logic [15:0] pulse_mask;
    logic [3:0]  r4_exp [4];
    logic [2:0]  c4_exp [4];
    int          cycles;
    bit          seen;

    reset = 1'b1; mode = USR_HOLD; par_in = '0; sin_right = 1'b0; sin_left = 1'b0;
    reset4 = 1'b1; mode4 = USR_HOLD; par_in4 = 4'h0; sin_right4 = 1'b0; sin_left4 = 1'b0;

    // 1. reset beats LOAD
    add(1, USR_LOAD, 8'hFF, 0, 0, 8'h00, 0, 0);
    add(1, USR_LOAD, 8'hFF, 0, 0, 8'h00, 0, 0);
    // 2. load then hold
    add(0, USR_LOAD, 8'hA5, 0, 0, 8'hA5, 0, 0);
    for (int i = 0; i < 3; i++) add(0, USR_HOLD, 8'h00, 1, 1, 8'hA5, 0, 0);
    // 3. serial in, right
    add(0, USR_LOAD, 8'h00, 0, 0, 8'h00, 0, 0);
    add(0, USR_SHR, 8'h00, 1, 0, 8'h80, 1, 0);
    add(0, USR_SHR, 8'h00, 0, 0, 8'h40, 2, 0);
    add(0, USR_SHR, 8'h00, 1, 0, 8'hA0, 3, 0);
    add(0, USR_SHR, 8'h00, 0, 0, 8'h50, 4, 0);
    add(0, USR_SHR, 8'h00, 1, 0, 8'hA8, 5, 0);
    add(0, USR_SHR, 8'h00, 0, 0, 8'h54, 6, 0);
    add(0, USR_SHR, 8'h00, 0, 0, 8'h2A, 7, 0);
    add(0, USR_SHR, 8'h00, 0, 0, 8'h15, 0, 1);
    // 4. shift left, parallel to serial
    add(0, USR_LOAD, 8'h81, 0, 0, 8'h81, 0, 0);
    add(0, USR_SHL, 8'h00, 0, 0, 8'h02, 1, 0);
    add(0, USR_SHL, 8'h00, 0, 0, 8'h04, 2, 0);
    add(0, USR_SHL, 8'h00, 0, 0, 8'h08, 3, 0);
    // 5. direction change and hold
    add(0, USR_SHR, 8'h00, 0, 0, 8'h04, 1, 0);
    add(0, USR_SHR, 8'h00, 0, 0, 8'h02, 2, 0);
    add(0, USR_SHR, 8'h00, 0, 0, 8'h01, 3, 0);
    add(0, USR_SHR, 8'h00, 0, 0, 8'h00, 4, 0);
    add(0, USR_SHR, 8'h00, 0, 0, 8'h00, 5, 0);
    add(0, USR_SHL, 8'h00, 0, 1, 8'h01, 1, 0);
    add(0, USR_SHL, 8'h00, 0, 1, 8'h03, 2, 0);
    add(0, USR_SHL, 8'h00, 0, 1, 8'h07, 3, 0);
    add(0, USR_SHL, 8'h00, 0, 1, 8'h0F, 4, 0);
    add(0, USR_HOLD, 8'h00, 0, 1, 8'h0F, 4, 0);
    add(0, USR_HOLD, 8'h00, 0, 1, 8'h0F, 4, 0);
    add(0, USR_SHL, 8'h00, 0, 0, 8'h1E, 5, 0);
    add(0, USR_SHL, 8'h00, 0, 0, 8'h3C, 6, 0);
    add(0, USR_SHL, 8'h00, 0, 0, 8'h78, 7, 0);
    add(0, USR_SHL, 8'h00, 0, 0, 8'hF0, 0, 1);
    // 6. reset mid-operation
    add(0, USR_SHR, 8'h00, 1, 0, 8'hF8, 1, 0);
    add(0, USR_SHR, 8'h00, 1, 0, 8'hFC, 2, 0);
    add(0, USR_SHR, 8'h00, 1, 0, 8'hFE, 3, 0);
    add(0, USR_SHR, 8'h00, 1, 0, 8'hFF, 4, 0);
    add(1, USR_SHR, 8'h00, 1, 0, 8'h00, 0, 0);
    add(0, USR_SHR, 8'h00, 1, 0, 8'h80, 1, 0);
    add(0, USR_SHR, 8'h00, 1, 0, 8'hC0, 2, 0);
    add(0, USR_SHR, 8'h00, 1, 0, 8'hE0, 3, 0);
    add(0, USR_SHR, 8'h00, 1, 0, 8'hF0, 4, 0);
    add(0, USR_SHR, 8'h00, 1, 0, 8'hF8, 5, 0);
    add(0, USR_SHR, 8'h00, 1, 0, 8'hFC, 6, 0);
    add(0, USR_SHR, 8'h00, 1, 0, 8'hFE, 7, 0);
    add(0, USR_SHR, 8'h00, 1, 0, 8'hFF, 0, 1);
    add(0, USR_HOLD, 8'h00, 0, 0, 8'hFF, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].md, vecs[i].par, vecs[i].sr, vecs[i].sl);
      sr_bits = vecs[i].res;
      check($sformatf("vec%0d Res", i), 32'(Res), 32'(vecs[i].res));
      check($sformatf("vec%0d shift_count", i), 32'(shift_count), 32'(vecs[i].cnt));
      check($sformatf("vec%0d word_ready", i), 32'(word_ready), 32'(vecs[i].wr));
      check($sformatf("vec%0d sout_lsb", i), 32'(sout_lsb), 32'(sr_bits[0]));
      check($sformatf("vec%0d sout_msb", i), 32'(sout_msb), 32'(sr_bits[7]));
    end

    // Wrap-around: 16 back-to-back left shifts pulse on the 8th and 16th.
    step(1, USR_HOLD, 8'h00, 0, 0);
    pulse_mask = '0;
    for (int k = 0; k < 16; k++) begin
      step(0, USR_SHL, 8'h00, 0, k[0]);
      pulse_mask[k] = word_ready;
    end
    check("wrap pulse positions", 32'(pulse_mask), 32'h8080);
    check("wrap Res", 32'(Res), 32'h55);
    check("wrap shift_count", 32'(shift_count), 32'd0);

    // LOAD in the middle of a run discards the partial count.
    for (int k = 0; k < 3; k++) step(0, USR_SHR, 8'h00, 0, 0);
    check("pre-load shift_count", 32'(shift_count), 32'd3);
    step(0, USR_LOAD, 8'h3C, 0, 0);
    check("load clears count", 32'(shift_count), 32'd0);
    check("load Res", 32'(Res), 32'h3C);
    cycles = 0;
    seen   = 1'b0;
    while (!seen && cycles < 20) begin
      step(0, USR_SHR, 8'h00, 0, 0);
      cycles++;
      seen = word_ready;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL word_ready timeout: got no pulse in %0d shifts need 8", cycles);
    end else begin
      check("shifts to word after load", 32'(cycles), 32'd8);
    end

    // Narrow instance with a non-zero reset value.
    step4(1, USR_HOLD, 0);
    check("w4 reset Res", 32'(res4), 32'hA);
    check("w4 reset count", 32'(shift_count4), 32'd0);
    check("w4 reset sout_msb", 32'(sout_msb4), 32'd1);
    r4_exp = '{4'h5, 4'h2, 4'h1, 4'h0};
    c4_exp = '{3'd1, 3'd2, 3'd3, 3'd0};
    for (int k = 0; k < 4; k++) begin
      step4(0, USR_SHR, 0);
      check($sformatf("w4 shr%0d Res", k), 32'(res4), 32'(r4_exp[k]));
      check($sformatf("w4 shr%0d count", k), 32'(shift_count4), 32'(c4_exp[k]));
      check($sformatf("w4 shr%0d word_ready", k), 32'(word_ready4), (k == 3) ? 32'd1 : 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
